spi_slave: RTL and testbench

- Serial front end that feeds the single-port RAM.
- Deserialises MOSI frames into 10-bit command words (2-bit opcode + 8-bit payload) and presents each on rx_data with a one-cycle rx_valid pulse.
- For read-data commands, captures the RAM's tx_data/tx_valid response and shifts the byte out on MISO.
- Serial bits are sampled and driven on the system clock.

---
 rtl/spi_slave_if.sv | 12 +
 rtl/spi_slave.sv | 83 ++++++++
 tb/tb_spi_slave.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// spi_slave_if: serial pins plus the RAM-side command/read-data signals of the SPI slave
interface spi_slave_if #(parameter int ADDR_SIZE = 8);
   logic                   SS_n;
   logic                   MOSI;
   logic                   MISO;
   logic [ADDR_SIZE+1:0]   rx_data;
   logic                   rx_valid;
   logic [ADDR_SIZE-1:0]   tx_data;
   logic                   tx_valid;
   modport slave (input SS_n, MOSI, tx_data, tx_valid, output MISO, rx_data, rx_valid);
   modport master (output SS_n, MOSI, tx_data, tx_valid, input MISO, rx_data, rx_valid);
endinterface

// File: rtl/spi_slave.sv
// spi_slave: deserialises MOSI command words for the RAM and shifts read bytes out on MISO
module spi_slave #(parameter int ADDR_SIZE = 8) (
   input logic       clk,
   input logic       rst_n,
   spi_slave_if.slave bus
);
   localparam int W  = ADDR_SIZE + 2;
   localparam int CW = $clog2(W + 1);
   localparam int TW = $clog2(ADDR_SIZE + 1);
   localparam logic [CW-1:0] LAST   = CW'(W - 1);
   localparam logic [CW-1:0] FULL   = CW'(W);
   localparam logic [TW-1:0] TX_END = TW'(ADDR_SIZE);

   typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

   state_t               state, state_d;
   logic [CW-1:0]        cnt;
   logic [W-2:0]         sh;
   logic [W-1:0]         rx_data;
   logic                 rx_valid;
   logic                 miso;
   logic                 rd_done;
   logic [ADDR_SIZE-1:0] tx_sh;
   logic [TW-1:0]        tx_cnt;
   logic                 take_bit, last_bit, load_tx, shift_tx, miso_d;

   assign bus.MISO     = miso;
   assign bus.rx_data  = rx_data;
   assign bus.rx_valid = rx_valid;

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_d;

   // next state: first command bit picks the frame type, SS_n high always returns to IDLE
   always_comb begin
      state_d = state;
      if (state == IDLE) state_d = bus.SS_n ? IDLE : CHK_CMD;
      else if (bus.SS_n) state_d = IDLE;
      else if (state == CHK_CMD) state_d = !bus.MOSI ? WRITE : rd_done ? READ_DATA : READ_ADD;
   end

   // control decode; tx load waits until the cycle after rx_valid so a stale tx_valid is ignored
   always_comb begin
      take_bit = !bus.SS_n && (state == CHK_CMD || (state != IDLE && cnt != FULL));
      last_bit = take_bit && cnt == LAST;
      load_tx  = !bus.SS_n && state == READ_DATA && cnt == FULL && !rx_valid && tx_cnt == '0 && bus.tx_valid;
      shift_tx = !bus.SS_n && state == READ_DATA && tx_cnt != '0 && tx_cnt != TX_END;
      miso_d   = load_tx ? bus.tx_data[ADDR_SIZE-1] : shift_tx ? tx_sh[ADDR_SIZE-1] : 1'b0;
   end

   // datapath: shift-in, rx strobe, read-address flag and MISO shift-out
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt      <= '0;
         sh       <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         miso     <= 1'b0;
         rd_done  <= 1'b0;
         tx_sh    <= '0;
         tx_cnt   <= '0;
      end else begin
         rx_valid <= last_bit;
         miso     <= miso_d;
         if (bus.SS_n || state == IDLE) begin
            cnt    <= '0;
            tx_cnt <= '0;
         end else begin
            if (take_bit) begin
               cnt <= cnt + CW'(1);
               sh  <= {sh[W-3:0], bus.MOSI};
            end
            if (load_tx || shift_tx) tx_cnt <= tx_cnt + TW'(1);
         end
         if (last_bit) rx_data <= {sh, bus.MOSI};
         if (last_bit && state == READ_ADD) rd_done <= 1'b1;
         if (last_bit && state == READ_DATA) rd_done <= 1'b0;
         if (load_tx) tx_sh <= {bus.tx_data[ADDR_SIZE-2:0], 1'b0};
         else if (shift_tx) tx_sh <= tx_sh << 1;
      end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed frames with a scoreboard monitor checking rx words and MISO bytes
module tb_spi_slave;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;
   bit          model_rd = 1'b0;
   logic [7:0]  ram_byte = 8'h00;
   logic [10:0] exp_q[$];
   logic [7:0]  byte_q[$];
   int          fc = -1;
   bit          rd_win = 1'b0;
   bit          prev_v = 1'b0;
   logic [10:0] e;
   logic [7:0]  cur_byte = 8'h00;
   logic [9:0]  last_rx = 10'h000;

   spi_slave_if #(.ADDR_SIZE(8)) bus ();
   spi_slave #(.ADDR_SIZE(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input bit ok, input string name, input int act, input int expv);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // monitor: pops expected words on rx_valid and checks MISO every cycle against the expected byte
   always @(negedge clk) begin
      if (!rst_n) begin
         fc = -1;
         rd_win = 1'b0;
         prev_v = 1'b0;
      end else begin
         fc = bus.SS_n ? -1 : fc + 1;
         if (bus.SS_n) rd_win = 1'b0;
         if (bus.rx_valid) begin
            check(!prev_v, "rx_valid_width", 1, 0);
            if (exp_q.size() == 0) check(1'b0, "unexpected_rx_valid", int'(bus.rx_data), 0);
            else begin
               e = exp_q.pop_front();
               check(bus.rx_data == e[9:0], "rx_data", int'(bus.rx_data), int'(e[9:0]));
               check(fc == 11, "rx_valid_cycle", fc, 11);
               if (e[10]) begin
                  cur_byte = byte_q.pop_front();
                  rd_win = 1'b1;
               end
            end
         end
         if (rd_win && fc >= 13 && fc <= 20) check(bus.MISO == cur_byte[20-fc], "miso_bit", int'(bus.MISO), int'(cur_byte[20-fc]));
         else check(bus.MISO == 1'b0, "miso_idle", int'(bus.MISO), 0);
         prev_v = bus.rx_valid;
      end
   end

   // RAM model: read-data opcode answered one cycle after rx_valid; tx_valid stays high
   always @(negedge clk)
      if (rst_n && bus.rx_valid && bus.rx_data[9:8] == 2'b11) begin
         @(posedge clk);
         #1;
         bus.tx_data = ram_byte;
         bus.tx_valid = 1'b1;
      end

   task automatic send(input logic [9:0] w, input int bits, input int rst_at);
      int  low;
      bit  rd_data;
      low = (bits == 10) ? 23 : bits + 1;
      if (bits == 10) begin
         rd_data = w[9] && model_rd;
         exp_q.push_back({rd_data, w});
         if (rd_data) byte_q.push_back(ram_byte);
         if (w[9]) model_rd = !model_rd;
         last_rx = w;
      end
      for (int c = 0; c < low; c++) begin
         @(posedge clk);
         #1;
         bus.SS_n = 1'b0;
         bus.MOSI = (c >= 1 && c <= bits) ? w[10-c] : 1'($urandom);
         if (c == rst_at) begin
            #1;
            check(bus.MISO == 1'b1, "miso_before_rst", int'(bus.MISO), 1);
            rst_n = 1'b0;
            #1;
            check(bus.MISO == 1'b0, "rst_miso", int'(bus.MISO), 0);
            check(bus.rx_valid == 1'b0, "rst_rx_valid", int'(bus.rx_valid), 0);
            check(dut.rd_done == 1'b0, "rst_rd_done", int'(dut.rd_done), 0);
            check(bus.rx_data == 10'h000, "rst_rx_data", int'(bus.rx_data), 0);
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.SS_n = 1'b1;
      bus.MOSI = 1'b0;
      if (rst_at >= 0) begin
         @(posedge clk);
         #1;
         rst_n = 1'b1;
         model_rd = 1'b0;
         last_rx = 10'h000;
      end
      @(posedge clk);
      #1;
      check(dut.rd_done == model_rd, "rd_addr_done", int'(dut.rd_done), int'(model_rd));
      check(bus.rx_data == last_rx, "rx_data_hold", int'(bus.rx_data), int'(last_rx));
   endtask

   initial begin
      bus.SS_n = 1'b1;
      bus.MOSI = 1'b0;
      bus.tx_data = 8'h00;
      bus.tx_valid = 1'b0;
      #12;
      check(bus.MISO == 1'b0, "reset_miso", int'(bus.MISO), 0);
      check(bus.rx_valid == 1'b0, "reset_rx_valid", int'(bus.rx_valid), 0);
      check(bus.rx_data == 10'h000, "reset_rx_data", int'(bus.rx_data), 0);
      check(dut.rd_done == 1'b0, "reset_rd_done", int'(dut.rd_done), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(10'h005, 10, -1);
      send(10'h1AA, 10, -1);
      send(10'h205, 10, -1);
      ram_byte = 8'hAA;
      send(10'h3FF, 10, -1);
      send(10'h2F0, 10, -1);
      ram_byte = 8'h3C;
      send(10'h311, 10, -1);
      send(10'h322, 10, -1);
      ram_byte = 8'h5A;
      send(10'h3C0, 10, -1);
      send(10'h155, 5, -1);
      send(10'h2AB, 5, -1);
      send(10'h0C3, 10, -1);
      send(10'h201, 10, -1);
      ram_byte = 8'hAA;
      send(10'h3FF, 10, 13);
      send(10'h2A5, 10, -1);
      repeat (3) @(posedge clk);
      check(exp_q.size() == 0, "rx_pending", exp_q.size(), 0);
      check(byte_q.size() == 0, "miso_pending", byte_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
